// File: rtl/matrix_arith_core.sv
// Sequential fixed-point matrix engine: matrix x matrix, scalar x matrix and matrix / scalar.
// All three share a single multiplier, round/saturate stage and element sequencer.
module matrix_arith_core #(
    parameter int SIZE_A    = 8,
    parameter int SIZE_B    = 512,
    parameter int SIZE_C    = 1,
    parameter int N_BITS    = 22,
    parameter int FRAC_BITS = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic signed [N_BITS-1:0] scale,
    input  logic signed [N_BITS-1:0] mat_a    [SIZE_A][SIZE_B],
    input  logic signed [N_BITS-1:0] mat_b    [SIZE_B][SIZE_C],
    output logic signed [N_BITS-1:0] prod_out [SIZE_A][SIZE_C],
    output logic signed [N_BITS-1:0] scal_out [SIZE_A][SIZE_B],
    output logic                     busy,
    output logic                     done,
    output logic                     div0,
    output logic                     op_err
);

    localparam int IW    = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int KW    = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam int JW    = (SIZE_C > 1) ? $clog2(SIZE_C) : 1;
    localparam int ACC_W = 2 * N_BITS + $clog2(SIZE_B);
    localparam int SW    = ACC_W + 2;
    localparam int DW    = N_BITS + FRAC_BITS + 1;

    localparam logic [IW-1:0] I_LAST = IW'(SIZE_A - 1);
    localparam logic [KW-1:0] K_LAST = KW'(SIZE_B - 1);
    localparam logic [JW-1:0] J_LAST = JW'(SIZE_C - 1);

    localparam logic signed [N_BITS-1:0] MAX_VAL    = {1'b0, {(N_BITS-1){1'b1}}};
    localparam logic signed [N_BITS-1:0] MIN_VAL    = {1'b1, {(N_BITS-1){1'b0}}};
    localparam logic signed [SW-1:0]     SAT_HI     = SW'(MAX_VAL);
    localparam logic signed [SW-1:0]     SAT_LO     = SW'(MIN_VAL);
    localparam logic signed [SW-1:0]     ROUND_BIAS = SW'(2 ** (FRAC_BITS - 1));

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_SMUL = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_SCL, S_DONE} state_t;

    state_t                    state_reg, state_next;
    logic [1:0]                op_reg;
    logic signed [N_BITS-1:0]  scale_reg;
    logic [IW-1:0]             i_reg;
    logic [JW-1:0]             j_reg;
    logic [KW-1:0]             k_reg;
    logic signed [ACC_W-1:0]   acc_reg;

    function automatic logic signed [N_BITS-1:0] saturate(input logic signed [SW-1:0] v);
        if (v > SAT_HI)
            saturate = MAX_VAL;
        else if (v < SAT_LO)
            saturate = MIN_VAL;
        else
            saturate = v[N_BITS-1:0];
    endfunction

    logic signed [N_BITS-1:0]   a_elem, b_elem, mult_rhs;
    logic signed [2*N_BITS-1:0] mult_prod;
    logic signed [ACC_W-1:0]    mac_sum;
    logic signed [SW-1:0]       rnd_shift;
    logic signed [N_BITS-1:0]   conv_res;
    logic signed [DW-1:0]       div_num, div_den, div_quo;
    logic                       scale_zero;
    logic signed [N_BITS-1:0]   div_res, scl_res;
    logic                       i_last, j_last, k_last;

    assign a_elem   = mat_a[i_reg][k_reg];
    assign b_elem   = mat_b[k_reg][j_reg];
    // The scalar replaces the mat_b operand so SMUL reuses the MAC multiplier.
    assign mult_rhs  = (state_reg == S_SCL) ? scale_reg : b_elem;
    assign mult_prod = (2*N_BITS)'(a_elem) * (2*N_BITS)'(mult_rhs);
    assign mac_sum   = ((state_reg == S_MUL) ? acc_reg : '0) + ACC_W'(mult_prod);
    assign rnd_shift = (SW'(mac_sum) + ROUND_BIAS) >>> FRAC_BITS;
    assign conv_res  = saturate(rnd_shift);

    // Numerator has one spare bit so MIN / -1 cannot wrap before saturation.
    assign scale_zero = (scale_reg == '0);
    assign div_num    = DW'(a_elem) <<< FRAC_BITS;
    assign div_den    = scale_zero ? DW'(1) : DW'(scale_reg);
    assign div_quo    = div_num / div_den;
    assign div_res    = scale_zero ? (a_elem[N_BITS-1] ? MIN_VAL : MAX_VAL)
                                   : saturate(SW'(div_quo));
    assign scl_res    = (op_reg == OP_SDIV) ? div_res : conv_res;

    assign i_last = (i_reg == I_LAST);
    assign j_last = (j_reg == J_LAST);
    assign k_last = (k_reg == K_LAST);

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MUL:           state_next = S_MUL;
                        OP_SMUL, OP_SDIV: state_next = S_SCL;
                        default:          state_next = S_DONE;
                    endcase
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (k_last && j_last && i_last)
                    state_next = S_DONE;
            end
            S_SCL: begin
                busy = 1'b1;
                if (k_last && i_last)
                    state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
            scale_reg <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            acc_reg   <= '0;
            div0      <= 1'b0;
            op_err    <= 1'b0;
            for (int r = 0; r < SIZE_A; r++) begin
                for (int c = 0; c < SIZE_C; c++)
                    prod_out[r][c] <= '0;
                for (int c = 0; c < SIZE_B; c++)
                    scal_out[r][c] <= '0;
            end
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_reg    <= op;
                        scale_reg <= scale;
                        div0      <= 1'b0;
                        op_err    <= (op == 2'b11);
                        i_reg     <= '0;
                        j_reg     <= '0;
                        k_reg     <= '0;
                        acc_reg   <= '0;
                    end
                end
                S_MUL: begin
                    if (k_last) begin
                        prod_out[i_reg][j_reg] <= conv_res;
                        acc_reg <= '0;
                        k_reg   <= '0;
                        if (j_last) begin
                            j_reg <= '0;
                            i_reg <= i_last ? '0 : i_reg + 1'b1;
                        end else begin
                            j_reg <= j_reg + 1'b1;
                        end
                    end else begin
                        acc_reg <= mac_sum;
                        k_reg   <= k_reg + 1'b1;
                    end
                end
                S_SCL: begin
                    scal_out[i_reg][k_reg] <= scl_res;
                    if ((op_reg == OP_SDIV) && scale_zero)
                        div0 <= 1'b1;
                    if (k_last) begin
                        k_reg <= '0;
                        i_reg <= i_last ? '0 : i_reg + 1'b1;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_arith_core.sv
// Directed bench for matrix_arith_core on a 2x2x2 configuration (1.0 = 2048).
module tb_matrix_arith_core;

    localparam int SA = 2;
    localparam int SB = 2;
    localparam int SC = 2;
    localparam int NB = 22;
    localparam int FB = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, start, busy, done, div0, op_err;
    logic [1:0]           op;
    logic signed [NB-1:0] scale;
    logic signed [NB-1:0] mat_a    [SA][SB];
    logic signed [NB-1:0] mat_b    [SB][SC];
    logic signed [NB-1:0] prod_out [SA][SC];
    logic signed [NB-1:0] scal_out [SA][SB];

    int n_checks = 0;
    int n_fail   = 0;

    matrix_arith_core #(
        .SIZE_A(SA), .SIZE_B(SB), .SIZE_C(SC), .N_BITS(NB), .FRAC_BITS(FB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .scale(scale),
        .mat_a(mat_a), .mat_b(mat_b), .prod_out(prod_out), .scal_out(scal_out),
        .busy(busy), .done(done), .div0(div0), .op_err(op_err)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_a(input int a00, input int a01, input int a10, input int a11);
        mat_a[0][0] = NB'(a00); mat_a[0][1] = NB'(a01);
        mat_a[1][0] = NB'(a10); mat_a[1][1] = NB'(a11);
    endtask

    task automatic set_b(input int b00, input int b01, input int b10, input int b11);
        mat_b[0][0] = NB'(b00); mat_b[0][1] = NB'(b01);
        mat_b[1][0] = NB'(b10); mat_b[1][1] = NB'(b11);
    endtask

    task automatic check_prod(input string tag, input int e00, input int e01, input int e10, input int e11);
        check({tag, " prod00"}, 32'(prod_out[0][0]), e00);
        check({tag, " prod01"}, 32'(prod_out[0][1]), e01);
        check({tag, " prod10"}, 32'(prod_out[1][0]), e10);
        check({tag, " prod11"}, 32'(prod_out[1][1]), e11);
    endtask

    task automatic check_scal(input string tag, input int e00, input int e01, input int e10, input int e11);
        check({tag, " scal00"}, 32'(scal_out[0][0]), e00);
        check({tag, " scal01"}, 32'(scal_out[0][1]), e01);
        check({tag, " scal10"}, 32'(scal_out[1][0]), e10);
        check({tag, " scal11"}, 32'(scal_out[1][1]), e11);
    endtask

    // lat = index of the first falling edge after E0 at which done is seen (0 = never).
    task automatic run_op(input logic [1:0] o, input int s, input bit hold,
                          output int lat, output logic busy_first, output logic busy_at_done);
        @(negedge clk);
        op    = o;
        scale = NB'(s);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        lat          = 0;
        busy_first   = 1'bx;
        busy_at_done = 1'bx;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) busy_first = busy;
            if (done) begin
                lat          = c;
                busy_at_done = busy;
                break;
            end
        end
        start = 1'b0;
        $display("op=%0d scale=%0d done at cycle %0d", o, s, lat);
    endtask

    int   lat, done_cnt;
    logic bf, bd;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        op    = 2'b00;
        scale = NB'(12345);
        set_a(7, -9, 100, 3);
        set_b(-5, 42, 8, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset div0", 32'(div0), 0);
        check("reset op_err", 32'(op_err), 0);
        check_prod("reset", 0, 0, 0, 0);
        check_scal("reset", 0, 0, 0, 0);
        start = 1'b0;
        rst_n = 1'b1;

        // MUL with identity A
        set_a(2048, 0, 0, 2048);
        set_b(4096, -2048, 1024, 3072);
        run_op(2'b00, 0, 1'b0, lat, bf, bd);
        check("mul latency", lat, 9);
        check("mul busy early", 32'(bf), 1);
        check("mul busy at done", 32'(bd), 0);
        check("mul op_err", 32'(op_err), 0);
        check_prod("mul id", 4096, -2048, 1024, 3072);
        check_scal("mul id", 0, 0, 0, 0);
        @(negedge clk);
        check("mul done width", 32'(done), 0);

        // SMUL by 0.5 with round half up
        set_a(4096, -3, 2047, 0);
        run_op(2'b01, 1024, 1'b0, lat, bf, bd);
        check("smul latency", lat, 5);
        check("smul busy early", 32'(bf), 1);
        check_scal("smul", 2048, -1, 1024, 0);
        check_prod("smul hold", 4096, -2048, 1024, 3072);

        // SMUL by 2.0 saturating both ways
        set_a(2097151, -2097152, 1, -1);
        run_op(2'b01, 4096, 1'b0, lat, bf, bd);
        check("smul sat latency", lat, 5);
        check_scal("smul sat", 2097151, -2097152, 2, -2);

        // MUL saturating at +max
        set_a(2097151, 2097151, 2097151, 2097151);
        set_b(2097151, 2097151, 2097151, 2097151);
        run_op(2'b00, 0, 1'b0, lat, bf, bd);
        check("mul sat latency", lat, 9);
        check_prod("mul sat", 2097151, 2097151, 2097151, 2097151);

        // SDIV by 2.0 truncates toward zero
        set_a(6144, -6144, 0, 1);
        run_op(2'b10, 4096, 1'b0, lat, bf, bd);
        check("sdiv latency", lat, 5);
        check_scal("sdiv", 3072, -3072, 0, 0);
        check("sdiv div0", 32'(div0), 0);

        // SDIV by zero
        run_op(2'b10, 0, 1'b0, lat, bf, bd);
        check("sdiv0 latency", lat, 5);
        check_scal("sdiv0", 2097151, -2097152, 2097151, 2097151);
        check("sdiv0 div0", 32'(div0), 1);

        // Invalid op: immediate done, clears div0, sets op_err
        run_op(2'b11, 0, 1'b0, lat, bf, bd);
        check("op11 latency", lat, 1);
        check("op11 busy", 32'(bf), 0);
        check("op11 op_err", 32'(op_err), 1);
        check("op11 div0 cleared", 32'(div0), 0);
        check("op11 scal hold", 32'(scal_out[0][1]), -2097152);

        // MUL with start held high throughout
        set_a(2048, 2048, 0, -2048);
        set_b(2048, 4096, -1024, 512);
        run_op(2'b00, 0, 1'b1, lat, bf, bd);
        check("held latency", lat, 9);
        check("held op_err cleared", 32'(op_err), 0);
        check_prod("held", 1024, 4608, 1024, -512);
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("held no restart", done_cnt, 0);

        // Reset in the middle of a MUL
        set_a(2048, 0, 0, 2048);
        @(negedge clk);
        op    = 2'b00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst busy before", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst busy", 32'(busy), 0);
        check("midrst done", 32'(done), 0);
        check_prod("midrst", 0, 0, 0, 0);
        check_scal("midrst", 0, 0, 0, 0);
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst no done", done_cnt, 0);
        $display("reset mid-MUL: done pulses after reset %0d", done_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
